s_vdelaynx: RTL and testbench
=============================

S_VDELAYNX -- requirements
Module: s_vdelaynx

Interface
REQ-001 SHALL have parameter SIZE, default 8: data width in bits.
REQ-002 SHALL have parameter MAXDLY, default 16: maximum delay in enabled cycles, power of two, 2 to 256.
REQ-003 SHALL have parameter RST_VAL, default {SIZE{1'b0}}: reset value of qn.
REQ-004 SHALL have localparam AW = clog2(MAXDLY).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1: advance enable; when 0, the block holds all state.
REQ-008 SHALL have port dly, input, AW+1: requested latency L in enabled cycles.
REQ-009 SHALL have port d, input, SIZE: input sample.
REQ-010 SHALL have port qn, output, SIZE, registered: d delayed by L enabled cycles.
REQ-011 SHALL have port qv, output, 1, registered: qn holds a sample written under the current L.

Function
REQ-012 SHALL compute L from dly: dly=0 gives L=1; dly>MAXDLY gives L=MAXDLY; otherwise L=dly.
REQ-013 SHALL keep a ring buffer of MAXDLY entries indexed by write pointer wptr (AW bits).
REQ-014 SHALL, on each edge with en=1, write d to buf[wptr] and increment wptr modulo MAXDLY; wrap from MAXDLY-1 to 0 is seamless.
REQ-015 SHALL, on each edge with en=1, load qn with d when L=1, else with buf[(wptr-(L-1)) mod MAXDLY], using pre-edge wptr.
REQ-016 SHALL, with en held at 1, present the sample applied at cycle k on qn from edge k+L; latency is exactly L.
REQ-017 SHALL, on each edge with en=0, hold qn, qv, wptr, the fill count and the buffer unchanged.
REQ-018 SHALL register the effective L into dly_r and compare L against dly_r every cycle, regardless of en.
REQ-019 SHALL implement FSM states IDLE, FILL and RUN.
REQ-020 SHALL leave IDLE for FILL on the first edge with en=1.
REQ-021 SHALL, in FILL, increment fill count cnt on each en edge and set qv=1 on the edge where pre-edge cnt = L-1, moving to RUN.
REQ-022 SHALL stay in RUN with qv=1 until reset or a change of L.
REQ-023 SHALL, when L != dly_r, load dly_r with L, clear qv to 0 and enter FILL.
REQ-024 SHALL, in the REQ-023 case, load cnt with 1 if en=1 on the same edge (write and qn load still occur under the new L), else with 0.
REQ-025 SHALL make a change of L take priority over the FILL-to-RUN transition on the same edge.
REQ-026 SHALL, when L=1, set qv on the first en edge after entering FILL.
REQ-027 SHALL saturate cnt at MAXDLY; cnt never wraps.
REQ-028 SHALL NOT clear buffer contents on a change of L; stale samples are masked only by qv.

Reset
REQ-029 SHALL, while rst=1, immediately force qn=RST_VAL, qv=0, wptr=0, cnt=0, dly_r=1 and state=IDLE.
REQ-030 SHALL NOT reset the buffer entries; qv=0 masks them.
REQ-031 SHALL, when rst is asserted mid-FILL or mid-RUN, abandon the operation; after release, behaviour is identical to first power-up.

Structure
REQ-032 SHALL place the state encoding (IDLE/FILL/RUN) and the clog2 helper in shared package s_vdelay_pkg.
REQ-033 SHALL implement the buffer as sub-module s_vdelay_ram: one write port, one asynchronous read port, SIZE x MAXDLY, no reset.
REQ-034 SHALL keep the top level to FSM, pointer, counter, clamp and output registers, with no other sub-modules.

Verification
REQ-035 SHALL cover: reset, en=1, dly=3, d=1,2,3,... per cycle -> qn=1 and qv=1 at the 3rd edge; qn=2 at the 4th.
REQ-036 SHALL cover: dly=0 and dly=1 with d=0xA5 -> qn=0xA5 and qv=1 one edge later, identically for both.
REQ-037 SHALL cover: dly=40 with MAXDLY=16, 40 en cycles -> clamped L=16; qv rises at the 16th edge; qn equals the input 16 cycles earlier across a wptr wrap.
REQ-038 SHALL cover: in RUN with dly=4, switch dly to 2 together with en=1 -> qv=0 on that edge, qv=1 on the next en edge, and qn tracks a 2-cycle delay thereafter.
REQ-039 SHALL cover: in FILL with dly=5, toggle en 1,0,0,1,... -> qv rises only at the 5th en=1 edge; qn and qv are frozen during en=0.
REQ-040 SHALL cover: assert rst asynchronously mid-RUN -> qn=RST_VAL and qv=0 immediately without a clock edge; after release, the REQ-035 sequence repeats exactly.

Source files
------------

// File: rtl/s_vdelay_pkg.sv
// s_vdelay_pkg: shared state encoding and width helper for the s_vdelaynx delay line.
// Revision 1.0
`default_nettype none

package s_vdelay_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time sizing; returns at least 1 so a
    // two-entry buffer still gets a real pointer bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/s_vdelay_ram.sv
// s_vdelay_ram: SIZE x DEPTH sample store, one synchronous write port, one asynchronous read port.
// Revision 1.0
`default_nettype none

module s_vdelay_ram #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem [DEPTH];

    // No reset: stale entries are hidden by the valid flag in the parent.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/s_vdelaynx.sv
// s_vdelaynx: enable-gated variable-latency delay line with latency clamp and fill-tracking valid flag.
// Revision 1.0
`default_nettype none

module s_vdelaynx
    import s_vdelay_pkg::*;
#(
    parameter int              SIZE    = 8,
    parameter int              MAXDLY  = 16,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [s_vdelay_pkg::clog2(MAXDLY):0] dly,
    input  logic [SIZE-1:0]              d,
    output logic [SIZE-1:0]              qn,
    output logic                         qv
);

    localparam int             AW    = clog2(MAXDLY);
    localparam int             LW    = AW + 1;
    localparam logic [AW:0]    MAX_L = LW'(MAXDLY);
    localparam logic [AW:0]    ONE_L = LW'(1);

    state_t            state, state_nx;
    logic [AW:0]       cnt, cnt_nx;
    logic [AW:0]       dly_r, dly_r_nx;
    logic [AW-1:0]     wptr, wptr_nx;
    logic [AW-1:0]     raddr;
    logic [SIZE-1:0]   rdata;
    logic [SIZE-1:0]   qn_nx;
    logic              qv_nx;
    logic [AW:0]       eff_l;

    always_comb begin
        if (dly == '0) begin
            eff_l = ONE_L;
        end else if (dly > MAX_L) begin
            eff_l = MAX_L;
        end else begin
            eff_l = dly;
        end
    end

    // wptr - (L-1) mod MAXDLY; when L = MAXDLY the low bits are zero and this
    // collapses to wptr + 1, which is the same slot.
    assign raddr = wptr + AW'(1) - eff_l[AW-1:0];

    s_vdelay_ram #(
        .SIZE  (SIZE),
        .DEPTH (MAXDLY),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (en),
        .waddr (wptr),
        .wdata (d),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dly_r <= ONE_L;
            wptr  <= '0;
            qn    <= RST_VAL;
            qv    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dly_r <= dly_r_nx;
            wptr  <= wptr_nx;
            qn    <= qn_nx;
            qv    <= qv_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dly_r_nx = dly_r;
        wptr_nx  = wptr;
        qn_nx    = qn;
        qv_nx    = qv;

        if (en) begin
            wptr_nx = wptr + AW'(1);
            qn_nx   = (eff_l == ONE_L) ? d : rdata;
        end

        // A latency change restarts the fill even with en low, and beats any
        // FILL-to-RUN completion on the same edge.
        if (eff_l != dly_r) begin
            dly_r_nx = eff_l;
            qv_nx    = 1'b0;
            state_nx = FILL;
            cnt_nx   = en ? ONE_L : '0;
        end else if (en) begin
            case (state)
                IDLE, FILL: begin
                    if (cnt >= eff_l - ONE_L) begin
                        qv_nx    = 1'b1;
                        state_nx = RUN;
                    end else begin
                        state_nx = FILL;
                        cnt_nx   = (cnt == MAX_L) ? cnt : cnt + ONE_L;
                    end
                end
                RUN: begin
                    qv_nx = 1'b1;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_s_vdelaynx.sv
// tb_s_vdelaynx: directed and randomized check of s_vdelaynx against a sample-history model.
// Revision 1.0
`default_nettype none

module tb_s_vdelaynx;

    localparam int SIZE   = 8;
    localparam int MAXDLY = 16;
    localparam int AW     = 4;

    logic            clk;
    logic            rst;
    logic            en;
    logic [AW:0]     dly;
    logic [SIZE-1:0] d;
    logic [SIZE-1:0] qn;
    logic            qv;

    int n_chk;
    int n_fail;

    // Model: full history of accepted samples plus enabled-edge count since
    // the last reset or latency change.
    logic [SIZE-1:0] hist [$];
    int              m_l;
    int              m_cnt;
    logic            m_qv;
    logic [SIZE-1:0] m_qn;

    s_vdelaynx #(
        .SIZE    (SIZE),
        .MAXDLY  (MAXDLY),
        .RST_VAL (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .dly (dly),
        .d   (d),
        .qn  (qn),
        .qv  (qv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp_l(input logic [AW:0] v);
        if (v == 0) return 1;
        if (int'(v) > MAXDLY) return MAXDLY;
        return int'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_l   = 1;
        m_cnt = 0;
        m_qv  = 1'b0;
        m_qn  = 8'h00;
    endtask

    task automatic model_step(input logic e, input logic [AW:0] dl, input logic [SIZE-1:0] dd);
        int l;
        l = clamp_l(dl);
        if (e) begin
            hist.push_back(dd);
            if (hist.size() >= l) m_qn = hist[hist.size() - l];
        end
        if (l != m_l) begin
            m_l   = l;
            m_cnt = e ? 1 : 0;
            m_qv  = 1'b0;
        end else if (e) begin
            m_cnt++;
            if (m_cnt >= m_l) m_qv = 1'b1;
        end
    endtask

    // Drive one cycle (inputs change 1 time unit after the edge), then compare.
    task automatic cycle(input logic e, input logic [AW:0] dl, input logic [SIZE-1:0] dd);
        en  = e;
        dly = dl;
        d   = dd;
        model_step(e, dl, dd);
        @(posedge clk);
        #1;
        chk("qv_vs_model", {31'd0, qv}, {31'd0, m_qv});
        if (m_qv) chk("qn_vs_model", {24'd0, qn}, {24'd0, m_qn});
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("reset_qn", {24'd0, qn}, 32'h0);
        chk("reset_qv", {31'd0, qv}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic seq_basic();
        cycle(1'b1, 5'd3, 8'd1);
        chk("basic_qv_e1", {31'd0, qv}, 32'h0);
        cycle(1'b1, 5'd3, 8'd2);
        chk("basic_qv_e2", {31'd0, qv}, 32'h0);
        cycle(1'b1, 5'd3, 8'd3);
        chk("basic_qn_e3", {24'd0, qn}, 32'd1);
        chk("basic_qv_e3", {31'd0, qv}, 32'h1);
        cycle(1'b1, 5'd3, 8'd4);
        chk("basic_qn_e4", {24'd0, qn}, 32'd2);
    endtask

    initial begin
        logic [AW:0] cur_dly;
        logic        e;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        en     = 1'b0;
        dly    = '0;
        d      = '0;
        model_reset();
        #2;
        do_reset();

        seq_basic();

        // Latency 1 from dly=0 and dly=1 must behave identically.
        do_reset();
        cycle(1'b1, 5'd0, 8'hA5);
        chk("dly0_qn", {24'd0, qn}, 32'hA5);
        chk("dly0_qv", {31'd0, qv}, 32'h1);
        do_reset();
        cycle(1'b1, 5'd1, 8'hA5);
        chk("dly1_qn", {24'd0, qn}, 32'hA5);
        chk("dly1_qv", {31'd0, qv}, 32'h1);

        // Over-range request (31 is the largest the 5-bit port can carry) clamps to 16.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b1, 5'd31, 8'(i));
            if (i == 15) chk("clamp_qv_e15", {31'd0, qv}, 32'h0);
            if (i == 16) begin
                chk("clamp_qv_e16", {31'd0, qv}, 32'h1);
                chk("clamp_qn_e16", {24'd0, qn}, 32'd1);
            end
            if (i == 40) chk("clamp_qn_e40", {24'd0, qn}, 32'd25);
        end

        // Latency change while running.
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 5'd4, 8'(100 + i));
        chk("chg_run_qv", {31'd0, qv}, 32'h1);
        cycle(1'b1, 5'd2, 8'd200);
        chk("chg_qv_drop", {31'd0, qv}, 32'h0);
        cycle(1'b1, 5'd2, 8'd201);
        chk("chg_qv_rise", {31'd0, qv}, 32'h1);
        chk("chg_qn_1", {24'd0, qn}, 32'd200);
        cycle(1'b1, 5'd2, 8'd202);
        chk("chg_qn_2", {24'd0, qn}, 32'd201);

        // Gapped enable during fill.
        do_reset();
        begin
            logic [9:0] pat;
            pat = 10'b1011011001;
            for (int k = 0; k < 10; k++) begin
                cycle(pat[k], 5'd5, 8'(50 + k));
                if (k == 6) chk("gap_qv_k6", {31'd0, qv}, 32'h0);
                if (k == 7) begin
                    chk("gap_qv_k7", {31'd0, qv}, 32'h1);
                    chk("gap_qn_k7", {24'd0, qn}, 32'd50);
                end
                if (k == 8) chk("gap_qn_hold", {24'd0, qn}, 32'd50);
                if (k == 9) chk("gap_qn_k9", {24'd0, qn}, 32'd53);
            end
        end

        // Asynchronous reset mid-RUN, then the first sequence again.
        do_reset();
        seq_basic();
        cycle(1'b1, 5'd3, 8'd5);
        #3;
        rst = 1'b1;
        #1;
        chk("async_qn", {24'd0, qn}, 32'h0);
        chk("async_qv", {31'd0, qv}, 32'h0);
        model_reset();
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seq_basic();

        // Randomized traffic.
        cur_dly = 5'd6;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) cur_dly = 5'($urandom_range(0, 31));
            e = ($urandom_range(0, 3) != 0);
            cycle(e, cur_dly, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
